// File: rtl/timing_pkg.sv
// Shared types and helpers for the two-level T/M timing sequencer.
package timing_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Index width for a one-hot vector of n strobes; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction

    // Limit a requested last-index to the highest strobe that physically exists.
    function automatic logic [3:0] clamp_last(input logic [3:0] req, input logic [3:0] max_idx);
        return (req > max_idx) ? max_idx : req;
    endfunction

endpackage

// File: rtl/timing_seq_if.sv
// Control/strobe bundle between the front-panel logic and the timing sequencer.
interface timing_seq_if #(
    parameter int T_WIDTH = 4,
    parameter int M_WIDTH = 3
);
    import timing_pkg::*;

    localparam int TL_W = idx_w(T_WIDTH);
    localparam int ML_W = idx_w(M_WIDTH);

    logic                run;
    logic                stop;
    logic                step_mode;
    logic                step;
    logic                wait_req;
    logic [TL_W-1:0]     t_last;
    logic [ML_W-1:0]     m_last;
    logic [T_WIDTH-1:0]  T;
    logic [M_WIDTH-1:0]  M;
    logic                beat_end;
    logic                inst_end;
    logic                running;

    modport master (
        output run, stop, step_mode, step, wait_req, t_last, m_last,
        input  T, M, beat_end, inst_end, running
    );

    modport slave (
        input  run, stop, step_mode, step, wait_req, t_last, m_last,
        output T, M, beat_end, inst_end, running
    );

endinterface

// File: rtl/timing_ring.sv
// One-hot rotating ring: load puts the token on bit 0, clear empties the ring,
// enable advances the token and wraps to bit 0 once the last index is reached.
module timing_ring
    import timing_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IW    = idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             load,
    input  logic             clr,
    input  logic             en,
    input  logic [IW-1:0]    last,
    output logic [WIDTH-1:0] q,
    output logic             at_last
);

    logic [IW-1:0] idx;

    // Encode the token position; an index at or past 'last' counts as last so a
    // shrunk length wraps cleanly on the next advance.
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (q[i]) idx = i[IW-1:0];
        end
        at_last = (|q) && (idx >= last);
    end

    // Token register: load beats clear beats advance.
    always_ff @(posedge clk or negedge clrn) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!clrn)        q <= '0;
        else if (load)    q <= WIDTH'(1);
        else if (clr)     q <= '0;
        else if (en)      q <= at_last ? WIDTH'(1) : {q[WIDTH-2:0], q[WIDTH-1]};
    end

endmodule

// File: rtl/timing_seq.sv
// Two-level machine-cycle/beat sequencer with programmable lengths, wait
// states, graceful stop at instruction end and single-instruction stepping.
module timing_seq
    import timing_pkg::*;
#(
    parameter int T_WIDTH = 4,
    parameter int M_WIDTH = 3
) (
    input  logic         clk,
    input  logic         clrn,
    timing_seq_if.slave  bus
);

    localparam int TL_W = idx_w(T_WIDTH);
    localparam int ML_W = idx_w(M_WIDTH);

    state_t              state_q, state_d;
    logic                stop_pend_q, stop_pend_d;
    logic                ring_load, ring_clr, t_en, m_en;
    logic [TL_W-1:0]     eff_t;
    logic [ML_W-1:0]     eff_m;
    logic [T_WIDTH-1:0]  t_q;
    logic [M_WIDTH-1:0]  m_q;
    logic                t_at_last, m_at_last;
    logic                beat_end_w, inst_end_w;

    assign eff_t = TL_W'(clamp_last(4'(bus.t_last), 4'(T_WIDTH - 1)));
    assign eff_m = ML_W'(clamp_last(4'(bus.m_last), 4'(M_WIDTH - 1)));

    assign beat_end_w = (state_q == RUN) && !bus.wait_req && t_at_last;
    assign inst_end_w = beat_end_w && m_at_last;

    timing_ring #(.WIDTH(T_WIDTH)) u_t_ring (
        .clk(clk), .clrn(clrn), .load(ring_load), .clr(ring_clr),
        .en(t_en), .last(eff_t), .q(t_q), .at_last(t_at_last)
    );

    timing_ring #(.WIDTH(M_WIDTH)) u_m_ring (
        .clk(clk), .clrn(clrn), .load(ring_load), .clr(ring_clr),
        .en(m_en), .last(eff_m), .q(m_q), .at_last(m_at_last)
    );

    // Sequencer state and the latched stop request.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= IDLE;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    // Next state and ring controls; stop/step are only honoured at instruction end.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        ring_load   = 1'b0;
        ring_clr    = 1'b0;
        t_en        = 1'b0;
        m_en        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.run) begin
                    state_d     = RUN;
                    ring_load   = 1'b1;
                    stop_pend_d = bus.stop;
                end
            end
            RUN: begin
                t_en = !bus.wait_req;
                m_en = !bus.wait_req && t_at_last;
                if (inst_end_w) begin
                    if (stop_pend_q || bus.stop) begin
                        state_d     = IDLE;
                        ring_clr    = 1'b1;
                        stop_pend_d = 1'b0;
                    end else if (bus.step_mode) begin
                        state_d  = PAUSE;
                        ring_clr = 1'b1;
                    end
                end else if (bus.stop) begin
                    stop_pend_d = 1'b1;
                end
            end
            PAUSE: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (bus.step || (!bus.step_mode && bus.run)) begin
                    state_d   = RUN;
                    ring_load = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.T        = t_q;
    assign bus.M        = m_q;
    assign bus.beat_end = beat_end_w;
    assign bus.inst_end = inst_end_w;
    assign bus.running  = (state_q == RUN);

endmodule

// File: doc/timing_seq.md
Name: timing_seq

Overview:
- Parametrised successor to the single-ring beat generator: a two-level sequencer that produces one-hot machine-cycle (M) and beat (T) strobes for the microprogrammed CPU.
- Adds per-instruction programmable lengths, wait-state insertion, graceful stop and single-instruction step mode.
- Sits between the front-panel/control logic and the microcontroller; every T/M consumer keys off its outputs.

Parameters:
- T_WIDTH, 4, number of beat strobes (T0..T_WIDTH-1); legal range 2..16.
- M_WIDTH, 3, number of machine-cycle strobes (M0..M_WIDTH-1); legal range 2..16.
- TL_W, $clog2(T_WIDTH), width of t_last (localparam).
- ML_W, $clog2(M_WIDTH), width of m_last (localparam).

Ports:
- clk  in  1  system clock, rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- run  in  1  start request; level, sampled each clk.
- stop  in  1  stop request; takes effect at instruction end.
- step_mode  in  1  1 = pause after every instruction.
- step  in  1  in PAUSE, start one more instruction.
- wait_req  in  1  freeze T/M this cycle (wait state).
- t_last  in  TL_W  index of last beat in the current machine cycle.
- m_last  in  ML_W  index of last machine cycle in the current instruction.
- T  out  T_WIDTH  one-hot beat strobe, all-zero when not running.
- M  out  M_WIDTH  one-hot machine-cycle strobe, all-zero when not running.
- beat_end  out  1  comb: running & !wait_req & current beat == eff t_last.
- inst_end  out  1  comb: beat_end & current M == eff m_last.
- running  out  1  1 in RUN.

Behaviour:
- Reset (clrn=0, asynchronous):
  - state=IDLE; T=0, M=0, running=0, stop_pend=0.
  - Reset release takes effect on the first clk edge.
- Effective lengths:
  - eff_t = min(t_last, T_WIDTH-1); eff_m = min(m_last, M_WIDTH-1).
  - Both are sampled combinationally every cycle, so they may change between machine cycles.
- States: IDLE, RUN, PAUSE.
- IDLE:
  - T=0, M=0.
  - run=1 → next edge: RUN, T=1 (T0), M=1 (M0). If stop=1 in the same cycle, stop_pend is set.
  - stop alone is ignored.
- RUN, advance rules:
  - wait_req=1: hold T, M and state; beat_end=inst_end=0.
  - Otherwise, if current beat index < eff_t: T rotates left by one.
  - At beat index == eff_t: T returns to T0, and M rotates (or returns to M0 when M index == eff_m).
- RUN, instruction end (inst_end=1 edge), first match wins:
  - (stop_pend | stop) → IDLE, T=M=0, stop_pend cleared.
  - step_mode → PAUSE, T=M=0.
  - Else wrap to T0/M0 and stay in RUN.
- RUN, other cases:
  - stop=1 at any non-inst_end cycle sets stop_pend.
  - run is ignored.
- PAUSE:
  - T=M=0.
  - stop → IDLE.
  - Else step=1 → RUN with T0/M0.
  - Else, if step_mode drops and run=1 → RUN.
- Boundaries:
  - A stale index beyond a shrunk eff_t/eff_m wraps to 0 on the next advance (index ≥ last treated as last).
  - wait_req on the last beat delays both beat_end and the stop/step decision.
- Invariant: outside reset, T and M are each one-hot in RUN and all-zero in IDLE/PAUSE.

Decomposition:
- Package timing_pkg:
  - state enum typedef (IDLE, RUN, PAUSE).
  - Clamp function for eff_t/eff_m.
  - Width localparam helpers.
- Sub-module timing_ring (parameter WIDTH):
  - One-hot ring with async active-low reset to 0.
  - Sync load-first, enable, and last-index input; outputs the one-hot vector and an at_last flag.
  - Instantiated twice: the T ring, and the M ring enabled by the T ring's at_last.

Test Plan:
- Reset, then run pulse, default lengths (t_last=3, m_last=2) → T sequence 1,2,4,8 repeats; M advances 1→2→4 every 4 clocks; inst_end every 12th clock.
- t_last=1, m_last=0 → T alternates 1,2; M stays 1; inst_end every 2nd clock.
- Stop asserted at M1/T2 → RUN continues to M2/T3 inst_end, then T=M=0, running=0 next cycle.
- wait_req high 3 cycles at T1 → T holds 2 for 4 clocks total; beat_end=0 throughout; sequence resumes with T=4.
- step_mode=1 → one full instruction (12 clocks), then PAUSE with T=M=0; step pulse → exactly one more instruction.
- clrn low mid-instruction (T=4, M=2) → T=M=0 and running=0 immediately, without a clock edge; run restarts at T0/M0.
